// File: rtl/change_dispenser.sv
// Greedy coin change dispenser: pays change_in using 10/5/2/1 coins and skips any empty tube.
// Each coin takes 1+PULSE_CYCLES+GAP_CYCLES cycles; start is ignored while busy, with no queuing.
module change_dispenser #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] change_in,
  input  logic       empty10,
  input  logic       empty5,
  input  logic       empty2,
  input  logic       empty1,
  output logic       coin10_out,
  output logic       coin5_out,
  output logic       coin2_out,
  output logic       coin1_out,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] remaining,
  output logic [3:0] coins_paid
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE, S_FAULT
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [3:0]      coin_q;      // one-hot {10,5,2,1}, registered so outputs never glitch
  logic [3:0]      val_q;       // value of the coin in progress
  logic [3:0]      pick;
  logic [3:0]      pick_val;
  logic            pulse_last;
  logic            gap_last;

  assign pulse_last = (cnt == CW'(PULSE_CYCLES - 1));
  assign gap_last   = (cnt == CW'(GAP_CYCLES - 1));

  // Largest usable denomination that still fits the remainder.
  always_comb begin
    pick     = 4'b0000;
    pick_val = 4'd0;
    if (!empty10 && remaining >= 4'd10) begin
      pick     = 4'b1000;
      pick_val = 4'd10;
    end else if (!empty5 && remaining >= 4'd5) begin
      pick     = 4'b0100;
      pick_val = 4'd5;
    end else if (!empty2 && remaining >= 4'd2) begin
      pick     = 4'b0010;
      pick_val = 4'd2;
    end else if (!empty1 && remaining >= 4'd1) begin
      pick     = 4'b0001;
      pick_val = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = (change_in == 4'd0) ? S_DONE : S_SELECT;
      S_SELECT: state_next = (pick != 4'b0000) ? S_PULSE : S_FAULT;
      S_PULSE:  if (pulse_last) state_next = S_GAP;
      S_GAP:    if (gap_last) state_next = (remaining == 4'd0) ? S_DONE : S_SELECT;
      S_DONE:   state_next = S_IDLE;
      S_FAULT:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    fault = (state == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      coin_q     <= 4'b0000;
      val_q      <= 4'd0;
      remaining  <= 4'd0;
      coins_paid <= 4'd0;
    end else begin
      if ((state == S_PULSE || state == S_GAP) && state_next == state)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;

      if (state_next == S_PULSE)
        coin_q <= (state == S_SELECT) ? pick : coin_q;
      else
        coin_q <= 4'b0000;

      if (state == S_SELECT)
        val_q <= pick_val;

      if (state == S_IDLE && start) begin
        remaining  <= change_in;
        coins_paid <= 4'd0;
      end else if (state == S_PULSE && pulse_last) begin
        remaining  <= remaining - val_q;
        coins_paid <= (coins_paid == 4'd15) ? 4'd15 : coins_paid + 4'd1;
      end
    end
  end

  assign coin10_out = coin_q[3];
  assign coin5_out  = coin_q[2];
  assign coin2_out  = coin_q[1];
  assign coin1_out  = coin_q[0];

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table vectors, corner sequences and random payouts vs a greedy model.
module tb_change_dispenser;

  localparam int P = 2;
  localparam int G = 2;
  localparam int K = 1 + P + G;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] change_in;
  logic       empty10, empty5, empty2, empty1;
  logic       coin10_out, coin5_out, coin2_out, coin1_out;
  logic       busy, done, fault;
  logic [3:0] remaining, coins_paid;

  int n_checks = 0;
  int n_fail   = 0;

  int       exp_list[16];
  int       exp_n;
  bit       exp_fault;
  logic [3:0] exp_rem;

  typedef struct {
    logic [3:0]  amt;
    logic [3:0]  emp;       // {e10,e5,e2,e1}
    int          n;
    logic [63:0] coins;     // nibble i = i-th coin paid
    bit          flt;
    logic [3:0]  rem;
    int          restart;
    int          chg_at;
    logic [3:0]  chg_emp;
  } vec_t;

  vec_t tbl[12];

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .change_in  (change_in),
    .empty10    (empty10),
    .empty5     (empty5),
    .empty2     (empty2),
    .empty1     (empty1),
    .coin10_out (coin10_out),
    .coin5_out  (coin5_out),
    .coin2_out  (coin2_out),
    .coin1_out  (coin1_out),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .remaining  (remaining),
    .coins_paid (coins_paid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] enc(input int d);
    case (d)
      10:      return 4'b1000;
      5:       return 4'b0100;
      2:       return 4'b0010;
      1:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Greedy payout computed directly from the denomination rules.
  function automatic void model(input logic [3:0] amt, input logic [3:0] emp);
    int rem;
    int dn[4];
    bit found;
    dn = '{10, 5, 2, 1};
    rem = int'(amt);
    exp_n = 0;
    exp_fault = 1'b0;
    while (rem > 0 && !exp_fault) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!found && dn[i] <= rem && !emp[3-i]) begin
          exp_list[exp_n] = dn[i];
          exp_n++;
          rem -= dn[i];
          found = 1'b1;
        end
      end
      if (!found) exp_fault = 1'b1;
    end
    exp_rem = 4'(rem);
  endfunction

  function automatic int last_cycle();
    return exp_fault ? 2 + exp_n * K : 1 + exp_n * K;
  endfunction

  // Cycle 1 is the first cycle after the start edge; outputs sampled at each negedge.
  task automatic run_txn(input string name, input logic [3:0] amt, input logic [3:0] emp,
                         input int restart_at, input int chg_at, input logic [3:0] chg_emp);
    int last, off, idx, ph;
    logic [3:0] exp_coin;
    last = last_cycle();
    @(negedge clk);
    start = 1'b1;
    change_in = amt;
    {empty10, empty5, empty2, empty1} = emp;
    @(negedge clk);
    for (int c = 1; c <= last + 3; c++) begin
      exp_coin = 4'b0000;
      off = c - 1;
      idx = off / K;
      ph  = off % K;
      if (idx < exp_n && ph >= 1 && ph <= P) exp_coin = enc(exp_list[idx]);
      check($sformatf("%s c%0d coins/busy/done/fault", name, c),
            {57'd0, coin10_out, coin5_out, coin2_out, coin1_out, busy, done, fault},
            {57'd0, exp_coin, (c <= last), (c == last && !exp_fault), (c == last && exp_fault)});
      if (c == last || c == last + 3) begin
        check($sformatf("%s c%0d remaining", name, c), 64'(remaining), 64'(exp_rem));
        check($sformatf("%s c%0d coins_paid", name, c), 64'(coins_paid), 64'(exp_n));
      end
      start = (c == restart_at);
      change_in = (c == restart_at) ? 4'd7 : 4'($urandom);
      if (c == chg_at) {empty10, empty5, empty2, empty1} = chg_emp;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    exp_n = v.n;
    exp_fault = v.flt;
    exp_rem = v.rem;
    for (int i = 0; i < 16; i++) exp_list[i] = (i < v.n) ? int'(v.coins[4*i +: 4]) : 0;
  endtask

  initial begin
    tbl[0]  = '{4'd8,  4'b0000, 3,  64'h125,             1'b0, 4'd0, 0, 0, 4'b0000};
    tbl[1]  = '{4'd15, 4'b1000, 3,  64'h555,             1'b0, 4'd0, 0, 0, 4'b0000};
    tbl[2]  = '{4'd3,  4'b0001, 1,  64'h2,               1'b1, 4'd1, 0, 0, 4'b0000};
    tbl[3]  = '{4'd0,  4'b0000, 0,  64'h0,               1'b0, 4'd0, 0, 0, 4'b0000};
    tbl[4]  = '{4'd7,  4'b0000, 2,  64'h25,              1'b0, 4'd0, 2, 0, 4'b0000};
    tbl[5]  = '{4'd15, 4'b0000, 2,  64'h5A,              1'b0, 4'd0, 0, 0, 4'b0000};
    tbl[6]  = '{4'd15, 4'b1110, 15, 64'h111111111111111, 1'b0, 4'd0, 0, 0, 4'b0000};
    tbl[7]  = '{4'd7,  4'b0111, 0,  64'h0,               1'b1, 4'd7, 0, 0, 4'b0000};
    tbl[8]  = '{4'd9,  4'b0100, 5,  64'h12222,           1'b0, 4'd0, 0, 0, 4'b0000};
    tbl[9]  = '{4'd11, 4'b1001, 2,  64'h55,              1'b1, 4'd1, 0, 0, 4'b0000};
    tbl[10] = '{4'd10, 4'b0000, 1,  64'hA,               1'b0, 4'd0, 0, 2, 4'b1000};
    tbl[11] = '{4'd15, 4'b1000, 2,  64'hA5,              1'b0, 4'd0, 0, 3, 4'b0000};

    rst_n = 1'b0;
    start = 1'b0;
    change_in = 4'd0;
    {empty10, empty5, empty2, empty1} = 4'b0000;
    #12;
    check("reset state", {50'd0, coin10_out, coin5_out, coin2_out, coin1_out, busy, done, fault,
                          remaining, coins_paid},
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      load_vec(tbl[i]);
      run_txn($sformatf("vec%0d", i), tbl[i].amt, tbl[i].emp, tbl[i].restart, tbl[i].chg_at,
              tbl[i].chg_emp);
    end

    // Reset asserted between clock edges in the middle of a coin10 pulse.
    @(negedge clk);
    start = 1'b1;
    change_in = 4'd10;
    {empty10, empty5, empty2, empty1} = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset coin10", {62'd0, coin10_out, busy}, 64'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {50'd0, coin10_out, coin5_out, coin2_out, coin1_out, busy, done,
                                  fault, remaining, coins_paid},
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_vec(tbl[0]);
    run_txn("after-reset", tbl[0].amt, tbl[0].emp, 0, 0, 4'b0000);

    for (int t = 0; t < 40; t++) begin
      logic [3:0] amt, emp;
      int rs;
      amt = 4'($urandom_range(0, 15));
      emp = 4'($urandom & $urandom);
      model(amt, emp);
      rs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, last_cycle()) : 0;
      run_txn($sformatf("rand%0d", t), amt, emp, rs, 0, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter PULSE_CYCLES, default 2: high time of each coin-eject pulse, in clk cycles, minimum 1.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2: mandatory low time after each pulse, in clk cycles, minimum 1.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to pay out change_in; sampled only in IDLE.
REQ-006 change_in  input  4  change amount to pay out, 0..15.
REQ-007 empty10, empty5, empty2, empty1  input  1 each  coin tube for that denomination is empty; sampled only in SELECT.
REQ-008 coin10_out, coin5_out, coin2_out, coin1_out  output  1 each  eject pulse for one coin of that denomination.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse: full amount paid.
REQ-011 fault  output  1  one-cycle pulse: payout aborted because no usable coin fits the remainder.
REQ-012 remaining  output  4  amount still owed; holds its value after DONE or FAULT until the next accepted start.
REQ-013 coins_paid  output  4  coins ejected in the current or last transaction.

Function
REQ-014 States SHALL be IDLE, SELECT, PULSE, GAP, DONE, FAULT.
REQ-015 IDLE with start=1: latch change_in into remaining, clear coins_paid, then go to DONE if change_in==0, else go to SELECT.
REQ-016 In SELECT (one cycle), the block SHALL choose the largest d in {10,5,2,1} with d<=remaining and empty_d==0, then go to PULSE; if no d qualifies, it SHALL go to FAULT.
REQ-017 PULSE SHALL drive exactly the chosen coin<d>_out high for PULSE_CYCLES consecutive cycles, with all other coin outputs low.
REQ-018 On the last PULSE cycle, the block SHALL update remaining to remaining-d and coins_paid to coins_paid+1; both outputs reflect the new values from the first GAP cycle.
REQ-019 GAP SHALL hold all coin outputs low for GAP_CYCLES cycles, then go to DONE if remaining==0, else to SELECT.
REQ-020 DONE and FAULT SHALL each last one cycle, assert done or fault respectively, then return to IDLE.
REQ-021 At most one coin output SHALL be high in any cycle, and coin outputs SHALL be registered (glitch-free).
REQ-022 Per-coin cost SHALL be exactly 1+PULSE_CYCLES+GAP_CYCLES cycles (SELECT+PULSE+GAP); done SHALL rise on the cycle after the last GAP cycle.
REQ-023 start SHALL be ignored while busy=1; change_in is not re-sampled mid-transaction.
REQ-024 Tube-empty changes during PULSE or GAP SHALL NOT affect the coin in progress; they apply at the next SELECT.
REQ-025 remaining SHALL never underflow; arithmetic is 4-bit unsigned, and REQ-016 guarantees d<=remaining.
REQ-026 coins_paid SHALL saturate at 15; the maximum reachable value is 15 (fifteen 1-coins).

Reset
REQ-027 When rst is low, the block SHALL immediately force state=IDLE, all coin outputs=0, busy=0, done=0, fault=0, remaining=0 and coins_paid=0, including mid-pulse.
REQ-028 After rst deasserts, the first start SHALL be accepted no earlier than the first rising clk edge.

Verification
REQ-029 Defaults, all tubes full, start with change_in=8 -> pulses coin5, coin2, coin1 in that order, each 2 cycles high and 2 low; done 1 cycle after the final gap (start+16); remaining=0; coins_paid=3.
REQ-030 change_in=15, empty10=1 -> three coin5 pulses, then done; coins_paid=3.
REQ-031 change_in=3, empty1=1 -> one coin2 pulse, then fault; remaining=1; coins_paid=1; coin1_out is never high.
REQ-032 change_in=0 -> done on the cycle after the IDLE exit, no coin pulse, coins_paid=0.
REQ-033 start with change_in=7 asserted again during the first PULSE -> the second start is ignored, the payout is 5,2 only, and exactly one done pulse occurs.
REQ-034 rst driven low during a coin10 pulse -> coin10_out falls with no clk edge; busy=0, remaining=0; the next start behaves as it does from power-up.
